// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// CPU MEM stage vs debug/loader port, with starvation guard and hold.
module dm_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_LIMIT = 512
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_type,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_hold,
    output logic        dbg_rvalid,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_type,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0]  SMAX = 4'(STARVE_MAX);
    localparam logic [31:0] LIM  = 32'(ADDR_LIMIT);

    logic [3:0] starve_cnt;
    logic       cpu_gnt;
    logic       dbg_gnt;
    logic       cpu_legal;
    logic       dbg_legal;
    logic       sel_we;
    logic       sel_legal;

    // Alignment, type-code and range check for one access.
    function automatic logic legal(input logic [31:0] a,
                                   input logic [2:0]  t);
        logic ok;
        case (t)
            3'b000:          ok = (a[1:0] == 2'b00);
            3'b001, 3'b010:  ok = ~a[0];
            3'b011, 3'b100:  ok = 1'b1;
            default:         ok = 1'b0;
        endcase
        return ok && (a < LIM);
    endfunction

    assign cpu_legal = legal(cpu_addr, cpu_type);
    assign dbg_legal = legal(dbg_addr, 3'b000);

    // Priority grant: hold, then starvation relief, then CPU, then debug.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (dbg_hold) begin
            dbg_gnt = dbg_req;
        end else if (starve_cnt == SMAX && dbg_req) begin
            dbg_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dbg_req) begin
            dbg_gnt = 1'b1;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Route the granted port onto the memory bus; idle bus is all zero.
    always_comb begin
        sel_we    = 1'b0;
        sel_legal = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_type  = 3'b000;
        if (cpu_gnt) begin
            sel_we    = cpu_we;
            sel_legal = cpu_legal;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_type  = cpu_type;
        end else if (dbg_gnt) begin
            sel_we    = dbg_we;
            sel_legal = dbg_legal;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Writes are suppressed outright while reset is asserted.
    assign mem_we = rstn & sel_we & sel_legal;

    // Count cycles debug waits behind the CPU, saturating.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= 4'd0;
        end else if (dbg_req && cpu_gnt) begin
            if (starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // One-cycle response/error pulses and load data capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_rvalid <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= 32'd0;
            dbg_rvalid <= 1'b0;
            dbg_err    <= 1'b0;
            dbg_rdata  <= 32'd0;
        end else begin
            cpu_rvalid <= cpu_gnt & cpu_legal;
            cpu_err    <= cpu_gnt & ~cpu_legal;
            dbg_rvalid <= dbg_gnt & dbg_legal;
            dbg_err    <= dbg_gnt & ~dbg_legal;
            if (cpu_gnt && cpu_legal && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (dbg_gnt && dbg_legal && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a 128-word memory model.
// Inputs change 1 time unit after the rising edge.
module tb_dm_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_type;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_hold;
    logic        dbg_rvalid;
    logic        dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic [31:0] mem_rdata;

    logic [31:0] mem [128];
    logic        ovr_en;
    logic [31:0] ovr_val;

    int n_chk;
    int n_fail;
    int dbg_hits;

    dm_port_arbiter #(.STARVE_MAX(4), .ADDR_LIMIT(512)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_type(cpu_type),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_hold(dbg_hold),
        .dbg_rvalid(dbg_rvalid), .dbg_err(dbg_err),
        .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
    end

    assign mem_rdata = ovr_en ? ovr_val : mem[mem_addr[8:2]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rstn = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        cpu_type = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        dbg_hold = 0;
        ovr_en = 0; ovr_val = 0;

        #3;
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_cpu_err", 32'(cpu_err), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_mem_we", 32'(mem_we), 0);
        tick();
        tick();
        rstn = 1'b1;

        // CPU alone: sw then lw at 0x10
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10;
        cpu_wdata = 32'hDEADBEEF; cpu_type = 3'b000;
        #1;
        check("sw_stall", 32'(cpu_stall), 0);
        check("sw_mem_we", 32'(mem_we), 1);
        check("sw_mem_addr", mem_addr, 32'h10);
        check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        check("sw_rvalid", 32'(cpu_rvalid), 1);
        check("sw_rdata_hold", cpu_rdata, 0);
        cpu_we = 0;
        #1;
        check("lw_stall", 32'(cpu_stall), 0);
        check("lw_mem_we", 32'(mem_we), 0);
        tick();
        check("lw_rvalid", 32'(cpu_rvalid), 1);
        check("lw_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        tick();
        check("lw_rvalid_pulse", 32'(cpu_rvalid), 0);
        check("idle_mem_addr", mem_addr, 0);

        // Contention: CPU 4 slots, debug 1, CPU again
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_type = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
        dbg_hits = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont_stall_%0d", i), 32'(cpu_stall),
                  (i == 4) ? 32'd1 : 32'd0);
            tick();
            if (dbg_rvalid) dbg_hits++;
        end
        cpu_req = 0; dbg_req = 0;
        tick();
        if (dbg_rvalid) dbg_hits++;
        check("cont_dbg_rvalid_cnt", 32'(dbg_hits), 1);
        check("cont_dbg_rdata", dbg_rdata, 32'hDEADBEEF);

        // Misaligned word store
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h12;
        cpu_wdata = 32'h0BAD0BAD; cpu_type = 0;
        #1;
        check("mis_mem_we", 32'(mem_we), 0);
        tick();
        check("mis_err", 32'(cpu_err), 1);
        check("mis_rvalid", 32'(cpu_rvalid), 0);
        check("mis_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        // Illegal type code
        cpu_we = 0; cpu_addr = 32'h10; cpu_type = 3'b101;
        tick();
        check("badtype_err", 32'(cpu_err), 1);
        // Legal half load at 0x12
        cpu_type = 3'b001; cpu_addr = 32'h12;
        tick();
        check("half_rvalid", 32'(cpu_rvalid), 1);
        check("half_err", 32'(cpu_err), 0);
        // Debug read out of range
        cpu_req = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
        tick();
        check("range_dbg_err", 32'(dbg_err), 1);
        check("range_dbg_rvalid", 32'(dbg_rvalid), 0);
        dbg_req = 0;
        tick();
        check("range_dbg_err_pulse", 32'(dbg_err), 0);

        // dbg_hold: debug writes 0x0/0x4/0x8, CPU waits
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4; cpu_type = 0;
        dbg_hold = 1; dbg_req = 1; dbg_we = 1;
        for (int i = 0; i < 3; i++) begin
            dbg_addr = 32'(i * 4);
            dbg_wdata = 32'h11 * 32'(i + 1);
            #1;
            check($sformatf("hold_stall_%0d", i), 32'(cpu_stall), 1);
            check($sformatf("hold_mem_we_%0d", i), 32'(mem_we), 1);
            check($sformatf("hold_mem_addr_%0d", i), mem_addr,
                  32'(i * 4));
            tick();
            check($sformatf("hold_dbg_rvalid_%0d", i),
                  32'(dbg_rvalid), 1);
        end
        dbg_hold = 0; dbg_req = 0; dbg_we = 0;
        #1;
        check("hold_release_stall", 32'(cpu_stall), 0);
        tick();
        check("hold_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("hold_cpu_rdata", cpu_rdata, 32'h22);

        // Byte load pass-through
        cpu_addr = 32'h20; cpu_type = 3'b011;
        ovr_en = 1; ovr_val = 32'hA5A55A5A;
        #1;
        check("lb_mem_type", 32'(mem_type), 3);
        check("lb_mem_addr", mem_addr, 32'h20);
        tick();
        check("lb_rdata", cpu_rdata, 32'hA5A55A5A);
        ovr_en = 0;

        // Reset mid-access with starve counter partly built
        cpu_addr = 32'h10; cpu_type = 0;
        dbg_req = 1; dbg_addr = 32'h10;
        tick();
        tick();
        cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h77;
        #1;
        check("rstmid_mem_we_pre", 32'(mem_we), 1);
        rstn = 0;
        #1;
        check("rstmid_mem_we", 32'(mem_we), 0);
        check("rstmid_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rstmid_cpu_rdata", cpu_rdata, 0);
        check("rstmid_dbg_rdata", dbg_rdata, 0);
        tick();
        cpu_req = 0; dbg_req = 0; cpu_we = 0;
        tick();
        rstn = 1;
        tick();
        check("rstmid_no_rvalid", 32'(cpu_rvalid), 0);
        check("rstmid_no_dbg_rvalid", 32'(dbg_rvalid), 0);
        cpu_req = 1; cpu_addr = 32'h30;
        tick();
        check("rstmid_no_write", cpu_rdata, 0);
        cpu_addr = 32'h10; dbg_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rstmid_starve_%0d", i), 32'(cpu_stall),
                  (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        cpu_req = 0; dbg_req = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
